// File: rtl/dual_issue_controller_pkg.sv
// Shared front-end constants: pipeline-register masks, memory ops,
// controller state encoding and mask helpers.
package dual_issue_controller_pkg;

   localparam int NUM_PIPE_MASKS = 3;

   typedef logic [NUM_PIPE_MASKS-1:0] pipe_mask_t;

   localparam pipe_mask_t PIPE_REG_PC    = 3'b001;
   localparam pipe_mask_t PIPE_REG_IF_ID = 3'b010;
   localparam pipe_mask_t PIPE_REG_ID_EX = 3'b100;

   localparam pipe_mask_t PIPE_BUBBLE = PIPE_REG_IF_ID | PIPE_REG_ID_EX;

   localparam logic [1:0] MEM_OP_NONE  = 2'd0;
   localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
   localparam logic [1:0] MEM_OP_STORE = 2'd2;

   localparam int CTRL_STATE_BITS = 2;

   localparam logic [CTRL_STATE_BITS-1:0] CTRL_STATE_RUN      = 2'd0;
   localparam logic [CTRL_STATE_BITS-1:0] CTRL_STATE_LOAD_USE = 2'd1;
   localparam logic [CTRL_STATE_BITS-1:0] CTRL_STATE_FLUSH    = 2'd2;

   typedef enum logic [CTRL_STATE_BITS-1:0] {
      ST_RUN      = CTRL_STATE_RUN,
      ST_LOAD_USE = CTRL_STATE_LOAD_USE,
      ST_FLUSH    = CTRL_STATE_FLUSH
   } ctrl_state_e;

   function automatic logic has_id_ex(input pipe_mask_t m);
      return (m & PIPE_REG_ID_EX) != '0;
   endfunction

endpackage

// File: rtl/dual_issue_controller_sat_counter.sv
// Saturating up-counter with a 0/1/2 increment and synchronous reset.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, count} + {{(WIDTH-1){1'b0}}, inc};

   // Add the increment, clamping at all-ones on carry-out.
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (sum[WIDTH])
         count <= '1;
      else
         count <= sum[WIDTH-1:0];
   end

endmodule

// File: rtl/dual_issue_controller.sv
// Dual-issue sequencing controller: slot-order bit, branch flush FSM,
// final stall/nop/clear masks and issue/stall performance counters.
module dual_issue_controller
   import dual_issue_controller_pkg::*;
#(
   parameter int CNT_WIDTH    = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_PIPE_MASKS-1:0] hz_stall0,
   input  logic [NUM_PIPE_MASKS-1:0] hz_nop0,
   input  logic [NUM_PIPE_MASKS-1:0] hz_stall1,
   input  logic [NUM_PIPE_MASKS-1:0] hz_nop1,
   input  logic                      hz_clear0,
   input  logic                      hz_clear1,
   input  logic                      branch_taken,
   output logic                      first,
   output logic [NUM_PIPE_MASKS-1:0] stall0,
   output logic [NUM_PIPE_MASKS-1:0] nop0,
   output logic [NUM_PIPE_MASKS-1:0] stall1,
   output logic [NUM_PIPE_MASKS-1:0] nop1,
   output logic                      clear0,
   output logic                      clear1,
   output logic                      flushing,
   output logic [CNT_WIDTH-1:0]      issued_count,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      split_count,
   output logic [CNT_WIDTH-1:0]      flush_count
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   ctrl_state_e state;
   ctrl_state_e state_nxt;
   logic [2:0]  flush_cnt;
   logic [2:0]  flush_cnt_nxt;
   logic        first_nxt;

   logic        bubble;
   logic        is_lu;
   logic        is_split;
   logic        is_dual;
   logic [1:0]  issued_inc;

   // Classify this cycle; a branch or an active flush masks the hazard unit.
   always_comb begin
      bubble   = branch_taken | (state == ST_FLUSH);
      is_lu    = !bubble && has_id_ex(hz_nop0) && has_id_ex(hz_nop1)
                 && !hz_clear0 && !hz_clear1;
      is_split = !bubble && (hz_clear0 ^ hz_clear1);
      is_dual  = !bubble && !is_lu && !is_split;
   end

   // Final masks: bubble both slots during reset or flush, else pass through.
   always_comb begin
      stall0 = hz_stall0;
      nop0   = hz_nop0;
      stall1 = hz_stall1;
      nop1   = hz_nop1;
      clear0 = hz_clear0;
      clear1 = hz_clear1;
      if (reset || bubble) begin
         stall0 = '0;
         nop0   = PIPE_BUBBLE;
         stall1 = '0;
         nop1   = PIPE_BUBBLE;
         clear0 = 1'b0;
         clear1 = 1'b0;
      end
   end

   // Next state, flush countdown and slot-order bit.
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      first_nxt     = first;
      if (branch_taken) begin
         first_nxt     = 1'b1;
         flush_cnt_nxt = FLUSH_LOAD;
         state_nxt     = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
      end else begin
         case (state)
            ST_FLUSH: begin
               flush_cnt_nxt = (flush_cnt != 3'd0) ? flush_cnt - 3'd1 : 3'd0;
               state_nxt     = (flush_cnt > 3'd1) ? ST_FLUSH : ST_RUN;
            end
            default: begin
               state_nxt = is_lu ? ST_LOAD_USE : ST_RUN;
               if (is_split)
                  first_nxt = hz_clear0;
            end
         endcase
      end
   end

   // State, countdown and slot-order registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_RUN;
         flush_cnt <= 3'd0;
         first     <= 1'b1;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
         first     <= first_nxt;
      end
   end

   assign flushing   = (state == ST_FLUSH);
   assign issued_inc = is_dual ? 2'd2 : (is_split ? 2'd1 : 2'd0);

   sat_counter #(.WIDTH(CNT_WIDTH)) u_issued (
      .clk   (clk),
      .reset (reset),
      .inc   (issued_inc),
      .count (issued_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
      .clk   (clk),
      .reset (reset),
      .inc   ({1'b0, is_lu}),
      .count (stall_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_split (
      .clk   (clk),
      .reset (reset),
      .inc   ({1'b0, is_split}),
      .count (split_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_flush (
      .clk   (clk),
      .reset (reset),
      .inc   ({1'b0, branch_taken}),
      .count (flush_count)
   );

endmodule

// File: tb/tb_dual_issue_controller.sv
// Bench for dual_issue_controller: directed vectors, a cycle-level
// behavioural model and per-cycle output comparison.
module tb_dual_issue_controller;
   import dual_issue_controller_pkg::*;

   localparam int CW   = 4;
   localparam int FC   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    hz_stall0, hz_nop0, hz_stall1, hz_nop1;
   logic          hz_clear0, hz_clear1, branch_taken;
   logic          first, clear0, clear1, flushing;
   logic [2:0]    stall0, nop0, stall1, nop1;
   logic [CW-1:0] issued_count, stall_count, split_count, flush_count;

   int n_chk = 0;
   int n_fail = 0;

   bit armed = 0;
   bit m_first;
   int m_iss, m_stl, m_spl, m_fls, m_bleft;

   always #5 clk = ~clk;

   dual_issue_controller #(.CNT_WIDTH(CW), .FLUSH_CYCLES(FC)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .hz_stall0    (hz_stall0),
      .hz_nop0      (hz_nop0),
      .hz_stall1    (hz_stall1),
      .hz_nop1      (hz_nop1),
      .hz_clear0    (hz_clear0),
      .hz_clear1    (hz_clear1),
      .branch_taken (branch_taken),
      .first        (first),
      .stall0       (stall0),
      .nop0         (nop0),
      .stall1       (stall1),
      .nop1         (nop1),
      .clear0       (clear0),
      .clear1       (clear1),
      .flushing     (flushing),
      .issued_count (issued_count),
      .stall_count  (stall_count),
      .split_count  (split_count),
      .flush_count  (flush_count)
   );

   function automatic int sat(input int x);
      return (x > MAXC) ? MAXC : x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: one step per clock from the inputs held during that cycle.
   always @(posedge clk) begin
      if (reset) begin
         armed   = 1;
         m_first = 1;
         m_iss   = 0;
         m_stl   = 0;
         m_spl   = 0;
         m_fls   = 0;
         m_bleft = 0;
      end else if (armed) begin
         if (branch_taken) begin
            m_fls   = sat(m_fls + 1);
            m_first = 1;
            m_bleft = FC - 1;
         end else if (m_bleft > 0) begin
            m_bleft--;
         end else if ((hz_nop0 & PIPE_REG_ID_EX) != 0 &&
                      (hz_nop1 & PIPE_REG_ID_EX) != 0 &&
                      !hz_clear0 && !hz_clear1) begin
            m_stl = sat(m_stl + 1);
         end else if (hz_clear0 != hz_clear1) begin
            m_spl   = sat(m_spl + 1);
            m_iss   = sat(m_iss + 1);
            m_first = hz_clear0;
         end else begin
            m_iss = sat(m_iss + 2);
         end
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin
      if (armed) begin
         bit bub;
         bub = reset || branch_taken || (m_bleft > 0);
         chk("m_stall0", stall0, bub ? 0 : hz_stall0);
         chk("m_stall1", stall1, bub ? 0 : hz_stall1);
         chk("m_nop0", nop0, bub ? 6 : hz_nop0);
         chk("m_nop1", nop1, bub ? 6 : hz_nop1);
         chk("m_clear0", clear0, bub ? 0 : hz_clear0);
         chk("m_clear1", clear1, bub ? 0 : hz_clear1);
         chk("m_flushing", flushing, m_bleft > 0);
         chk("m_first", first, m_first);
         chk("m_issued", issued_count, m_iss);
         chk("m_stall_cnt", stall_count, m_stl);
         chk("m_split_cnt", split_count, m_spl);
         chk("m_flush_cnt", flush_count, m_fls);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      hz_stall0    = 0;
      hz_nop0      = 0;
      hz_stall1    = 0;
      hz_nop1      = 0;
      hz_clear0    = 0;
      hz_clear1    = 0;
      branch_taken = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_nop0", nop0, 6);
         chk("rst_nop1", nop1, 6);
         tick();
      end
      reset = 0;
      @(negedge clk);
      chk("rel_first", first, 1);
      chk("rel_issued", issued_count, 0);
      chk("rel_nop0", nop0, 0);
      tick();
      tick();
      hz_clear1 = 1;
      hz_stall0 = 3'b111;
      hz_nop0   = 3'b100;
      hz_stall1 = 3'b001;
      @(negedge clk);
      chk("dual_issued", issued_count, 4);
      chk("split_stall0", stall0, 7);
      chk("split_nop0", nop0, 4);
      chk("split_clear1", clear1, 1);
      tick();
      idle();
      hz_clear0 = 1;
      @(negedge clk);
      chk("split_first", first, 0);
      chk("split_cnt", split_count, 1);
      chk("split_issued", issued_count, 5);
      tick();
      idle();
      hz_nop0 = 3'b100;
      hz_nop1 = 3'b100;
      @(negedge clk);
      chk("b2b_first", first, 1);
      chk("b2b_split", split_count, 2);
      tick();
      tick();
      idle();
      branch_taken = 1;
      hz_clear1    = 1;
      @(negedge clk);
      chk("lu_stall_cnt", stall_count, 2);
      chk("lu_issued", issued_count, 6);
      chk("lu_first", first, 1);
      chk("br_nop1", nop1, 6);
      chk("br_clear1", clear1, 0);
      tick();
      branch_taken = 0;
      @(negedge clk);
      chk("fl_flushing", flushing, 1);
      chk("fl_clear1", clear1, 0);
      chk("fl_flush_cnt", flush_count, 1);
      tick();
      idle();
      @(negedge clk);
      chk("fl_done", flushing, 0);
      chk("fl_split", split_count, 2);
      chk("fl_first", first, 1);
      tick();
      branch_taken = 1;
      tick();
      @(negedge clk);
      chk("re_flushing", flushing, 1);
      tick();
      branch_taken = 0;
      @(negedge clk);
      chk("re_nop0", nop0, 6);
      chk("re_flush_cnt", flush_count, 3);
      tick();
      @(negedge clk);
      chk("re_done", flushing, 0);
      tick();
      branch_taken = 1;
      tick();
      branch_taken = 0;
      reset = 1;
      @(negedge clk);
      chk("rf_flushing", flushing, 1);
      tick();
      reset = 0;
      @(negedge clk);
      chk("rf_abort", flushing, 0);
      chk("rf_issued", issued_count, 0);
      repeat (10) tick();
      @(negedge clk);
      chk("sat_issued", issued_count, 15);
      repeat (2) tick();
      @(negedge clk);
      chk("sat_hold", issued_count, 15);
      reset = 1;
      tick();
      reset = 0;
      @(negedge clk);
      chk("sat_reset", issued_count, 0);
      tick();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
